// File: rtl/hazard5_regfile_dbg_ctrl_if.sv
// Debug-module side of the register-file port sequencer.
// Four-phase handshake: dbg_req (with dbg_write/dbg_addr/dbg_wdata) is held until
// dbg_ack rises; dbg_ack (with dbg_rdata stable) is held until dbg_req falls.
interface hazard5_regfile_dbg_ctrl_if #(
  parameter int W_ADDR = 5,
  parameter int W_DATA = 32
);
  logic              dbg_req;
  logic              dbg_write;
  logic [W_ADDR-1:0] dbg_addr;
  logic [W_DATA-1:0] dbg_wdata;
  logic              dbg_ack;
  logic [W_DATA-1:0] dbg_rdata;

  modport master (
    output dbg_req, dbg_write, dbg_addr, dbg_wdata,
    input  dbg_ack, dbg_rdata
  );

  modport slave (
    input  dbg_req, dbg_write, dbg_addr, dbg_wdata,
    output dbg_ack, dbg_rdata
  );
endinterface

// File: rtl/hazard5_regfile_dbg_ctrl.sv
// Shares the 1W/2R register file between the pipeline and the debug module,
// stealing read port 1 and the write port while the core is halted.
module hazard5_regfile_dbg_ctrl #(
  parameter int N_REGS = 32,
  parameter int W_DATA = 32,
  parameter int W_ADDR = $clog2(N_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halted,
  input  logic              core_ren,
  input  logic [W_ADDR-1:0] core_raddr1,
  input  logic [W_ADDR-1:0] core_raddr2,
  input  logic              wb_wen,
  input  logic [W_ADDR-1:0] wb_waddr,
  input  logic [W_DATA-1:0] wb_wdata,
  hazard5_regfile_dbg_ctrl_if.slave dbg,
  output logic              core_stall,
  output logic              rf_ren,
  output logic [W_ADDR-1:0] rf_raddr1,
  output logic [W_ADDR-1:0] rf_raddr2,
  output logic              rf_wen,
  output logic [W_ADDR-1:0] rf_waddr,
  output logic [W_DATA-1:0] rf_wdata,
  input  logic [W_DATA-1:0] rf_rdata1,
  output logic [2:0]        fsm_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    RESTORE = 3'd2,
    WR      = 3'd3,
    ACK     = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic              op_write_q;
  logic [W_ADDR-1:0] addr_q;
  logic [W_DATA-1:0] wdata_q;
  logic [W_ADDR-1:0] saved_raddr1_q;
  logic [W_DATA-1:0] dbg_rdata_q;
  logic              accept;

  assign accept = (state == IDLE) && dbg.dbg_req && halted;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      op_write_q     <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      saved_raddr1_q <= '0;
      dbg_rdata_q    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_write_q     <= dbg.dbg_write;
        addr_q         <= dbg.dbg_addr;
        wdata_q        <= dbg.dbg_wdata;
        saved_raddr1_q <= core_raddr1;
      end
      // The regfile registers its read, so the RD-cycle address returns here.
      if (state == RESTORE) dbg_rdata_q <= rf_rdata1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = dbg.dbg_write ? WR : RD;
      RD:      state_nxt = RESTORE;
      RESTORE: state_nxt = ACK;
      WR:      if (!wb_wen) state_nxt = ACK;
      ACK:     if (!dbg.dbg_req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rf_raddr2 = core_raddr2;
    rf_raddr1 = core_raddr1;
    rf_ren    = core_ren;
    if (state == RD) begin
      rf_raddr1 = addr_q;
      rf_ren    = 1'b1;
    end else if (state == RESTORE) begin
      rf_raddr1 = saved_raddr1_q;
      rf_ren    = 1'b1;
    end

    // Writeback always wins so the instruction draining into halt can retire.
    rf_wen   = 1'b0;
    rf_waddr = wb_waddr;
    rf_wdata = wb_wdata;
    if (wb_wen) begin
      rf_wen = 1'b1;
    end else if (state == WR && op_write_q) begin
      rf_wen   = (addr_q != '0);
      rf_waddr = addr_q;
      rf_wdata = wdata_q;
    end
  end

  assign core_stall    = (state != IDLE);
  assign dbg.dbg_ack   = (state == ACK);
  assign dbg.dbg_rdata = dbg_rdata_q;
  assign fsm_state     = state;

endmodule

// File: doc/hazard5_regfile_dbg_ctrl.md
# hazard5_regfile_dbg_ctrl

Port sequencer between the Hazard5 pipeline, the debug module and the 1-write/2-read register file. Passes pipeline reads and writebacks straight through. While the core is halted, it steals read port 1 and the write port to serve debug register reads and writes. After each debug read it reissues the pipeline's saved read address, so the core resumes with correct operands.

## Interface
- N_REGS, 32, number of architectural registers
- W_DATA, 32, register width
- W_ADDR, $clog2(N_REGS), register index width
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous and active-high
- halted  in  1  core halted; debug requests are accepted only while high
- core_ren  in  1  pipeline read enable
- core_raddr1, core_raddr2  in  W_ADDR  pipeline read addresses
- wb_wen  in  1  pipeline writeback enable
- wb_waddr  in  W_ADDR  writeback address
- wb_wdata  in  W_DATA  writeback data
- dbg_req  in  1  debug request, level; held until dbg_ack is seen
- dbg_write  in  1  1 = write, 0 = read; valid with dbg_req
- dbg_addr  in  W_ADDR  debug register index
- dbg_wdata  in  W_DATA  debug write data
- dbg_ack  out  1  request complete; held until dbg_req falls
- dbg_rdata  out  W_DATA  read result; stable while dbg_ack is high
- core_stall  out  1  high whenever state != IDLE; pipeline must not advance
- rf_ren  out  1  regfile read enable
- rf_raddr1, rf_raddr2  out  W_ADDR  regfile read addresses
- rf_wen  out  1  regfile write enable
- rf_waddr  out  W_ADDR  regfile write address
- rf_wdata  out  W_DATA  regfile write data
- rf_rdata1  in  W_DATA  regfile read port 1 data (registered inside the regfile)

## Operation
- States: IDLE, RD, RESTORE, WR, ACK.
- Latched registers: op_write_q, addr_q, wdata_q, saved_raddr1_q, dbg_rdata.
- IDLE, when dbg_req && halted:
  - Latch dbg_write, dbg_addr and dbg_wdata.
  - Latch core_raddr1 into saved_raddr1_q.
  - Go to RD if a read, WR if a write.
  - If not halted, the request waits; no ack.
- RD:
  - Drive rf_raddr1 = addr_q and rf_ren = 1.
  - Go to RESTORE.
- RESTORE:
  - rf_rdata1 now holds the debug value; latch it into dbg_rdata at the end of this cycle.
  - Drive rf_raddr1 = saved_raddr1_q and rf_ren = 1.
  - Go to ACK.
- WR:
  - If wb_wen, stay in WR; the pipeline writeback owns the port.
  - Otherwise drive rf_wen = (addr_q != 0), rf_waddr = addr_q, rf_wdata = wdata_q, then go to ACK.
  - A write to x0 is dropped but still acknowledged.
- ACK:
  - dbg_ack = 1.
  - Go to IDLE when dbg_req is low. This is a four-phase handshake: no new request is accepted in the cycle dbg_req falls.
- Default muxing outside the states above:
  - rf_raddr1 = core_raddr1, rf_raddr2 = core_raddr2 (always).
  - rf_ren = core_ren | (state in RD or RESTORE).
- Write-port priority:
  - wb_wen always wins: rf_wen/rf_waddr/rf_wdata = wb_* whenever wb_wen is high, in every state.
  - This lets the instruction draining on halt retire.
- Reads of x0 return 0 (the regfile masks them). No special casing here.
- Halted falling mid-operation:
  - The operation completes and acks normally.
  - core_stall keeps the pipeline frozen until IDLE.
- Reset values:
  - state = IDLE.
  - dbg_ack = 0, dbg_rdata = 0, core_stall = 0.
  - All latched registers = 0.
- Reset asserted mid-operation aborts it. Any dbg_req still high is re-accepted only after reset release.

## Timing
- The request is sampled at the end of cycle A (IDLE && dbg_req && halted).
- Read:
  - Cycle A+1: RD.
  - Cycle A+2: RESTORE.
  - Cycle A+3: first cycle with dbg_ack = 1.
  - Fixed 3-cycle latency.
- Write:
  - Cycle A+1: WR, rf_wen high if wb_wen is low.
  - Cycle A+2: dbg_ack = 1.
  - Each cycle of wb_wen held high in WR adds one cycle.
- core_stall is high from A+1 until the cycle after dbg_req falls in ACK.
- No combinational path from dbg_req or halted to any rf_* output.
  - The only combinational path is wb_wen to rf_wen/rf_waddr/rf_wdata.

## Test plan
- Debug read:
  - Stimulus: halted=1; preload x5=0xDEADBEEF; core_raddr1=7 with x7=0x12345678; read request for x5.
  - Response: dbg_ack rises 3 cycles after acceptance; dbg_rdata=0xDEADBEEF; after the restore read, rf_rdata1=0x12345678.
- Debug write:
  - Stimulus: halted=1; write x9=0xCAFEF00D; then read x9.
  - Response: write ack 2 cycles after acceptance; readback returns 0xCAFEF00D.
- Write collision:
  - Stimulus: write request for x3=0x1; wb_wen held 2 cycles writing x4=0x2.
  - Response: rf_wen carries wb data for both cycles; debug write occurs in the 3rd WR cycle; ack is 2 cycles late; x3=0x1, x4=0x2.
- x0 handling:
  - Stimulus: write x0=0xFFFFFFFF, then read x0.
  - Response: rf_wen never asserted for the debug write; both ops ack; read data = 0.
- Handshake gating:
  - Stimulus: dbg_req high while halted=0 for 10 cycles, then halted=1; dbg_req held high 5 cycles after ack.
  - Response: no acceptance before halted rises; dbg_ack stays high until dbg_req falls; exactly one operation is performed.
- Reset mid-read:
  - Stimulus: assert rst while in RESTORE.
  - Response: dbg_ack=0, dbg_rdata=0, core_stall=0 immediately (asynchronous); state=IDLE.
